// File: rtl/alineador_rx_pkg.sv
// rtl/alineador_rx_pkg.sv - shared state encodings and defaults for the RX symbol aligner
package alineador_rx_pkg;

    localparam logic [7:0] COM_DEFAULT           = 8'hBC;
    localparam int         COM_COUNT_DEFAULT     = 4;
    localparam int         TIMEOUT_BYTES_DEFAULT = 64;

    // Encodings are fixed so the later RX un-striping stage can decode them directly.
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_ALIGNED = 2'd2
    } state_t;

endpackage

// File: rtl/alineador_rx_if.sv
// rtl/alineador_rx_if.sv - serial lane in, aligned byte stream out
interface alineador_rx_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active_out;

    modport master (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active_out
    );

    modport slave (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active_out
    );

endinterface

// File: rtl/alineador_rx_detector_com.sv
// rtl/alineador_rx_detector_com.sv - bit shift register and COM pattern match
module detector_com
    import alineador_rx_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] cand,
    output logic       es_com
);

    // Only the last seven bits need storing; the eighth is the live input bit.
    logic [6:0] sr;

    assign cand   = {sr, data_in};
    assign es_com = (cand == COM_SYMBOL);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= cand[6:0];
        end
    end

endmodule

// File: rtl/alineador_rx.sv
// rtl/alineador_rx.sv - COM-based byte aligner for the serial RX lane
// Optional lock-loss timeout is built only when ALINEADOR_TIMEOUT_EN is defined.
module alineador_rx
    import alineador_rx_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL    = COM_DEFAULT,
    parameter int         COM_COUNT     = COM_COUNT_DEFAULT
`ifdef ALINEADOR_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_BYTES = TIMEOUT_BYTES_DEFAULT
`endif
) (
    input  logic           clk_32f,
    input  logic           reset,
    alineador_rx_if.master lane
);

    logic [7:0] cand;
    logic       es_com;

    detector_com #(.COM_SYMBOL(COM_SYMBOL)) u_detector (
        .clk_32f (clk_32f),
        .reset   (reset),
        .data_in (lane.data_in),
        .cand    (cand),
        .es_com  (es_com)
    );

    state_t     state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [3:0] com_cnt, com_cnt_nx;
    logic [7:0] data_q, data_nx;
    logic       valid_q, valid_nx;
    logic       strobe_q, strobe_nx;
    logic       boundary;
`ifdef ALINEADOR_TIMEOUT_EN
    logic [7:0] idle_cnt, idle_nx;
`endif

    assign boundary = (bit_cnt == 3'd7);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state    <= ST_SEARCH;
            bit_cnt  <= '0;
            com_cnt  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
`ifdef ALINEADOR_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            com_cnt  <= com_cnt_nx;
            data_q   <= data_nx;
            valid_q  <= valid_nx;
            strobe_q <= strobe_nx;
`ifdef ALINEADOR_TIMEOUT_EN
            idle_cnt <= idle_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt + 3'd1;
        com_cnt_nx = com_cnt;
        data_nx    = data_q;
        valid_nx   = valid_q;
        strobe_nx  = 1'b0;
`ifdef ALINEADOR_TIMEOUT_EN
        idle_nx    = idle_cnt;
`endif
        case (state)
            ST_SEARCH: begin
                valid_nx = 1'b0;
`ifdef ALINEADOR_TIMEOUT_EN
                idle_nx  = '0;
`endif
                // A hit on any bit position redefines the byte boundary.
                if (es_com) begin
                    bit_cnt_nx = '0;
                    com_cnt_nx = 4'd1;
                    state_nx   = (COM_COUNT == 1) ? ST_ALIGNED : ST_LOCKING;
                end
            end
            ST_LOCKING: begin
                valid_nx = 1'b0;
`ifdef ALINEADOR_TIMEOUT_EN
                idle_nx  = '0;
`endif
                if (boundary) begin
                    if (es_com) begin
                        com_cnt_nx = com_cnt + 4'd1;
                        if (com_cnt_nx == 4'(COM_COUNT)) begin
                            state_nx = ST_ALIGNED;
                        end
                    end else begin
                        state_nx   = ST_SEARCH;
                        com_cnt_nx = '0;
                    end
                end
            end
            ST_ALIGNED: begin
                if (boundary) begin
                    data_nx   = cand;
                    strobe_nx = 1'b1;
                    valid_nx  = !es_com;
`ifdef ALINEADOR_TIMEOUT_EN
                    if (es_com) begin
                        idle_nx = '0;
                    end else begin
                        idle_nx = idle_cnt + 8'd1;
                        // The byte that hits the limit is still emitted above.
                        if (idle_nx == 8'(TIMEOUT_BYTES)) begin
                            state_nx   = ST_SEARCH;
                            com_cnt_nx = '0;
                        end
                    end
`endif
                end
            end
            default: begin
                state_nx = ST_SEARCH;
            end
        endcase
    end

    assign lane.data_out    = data_q;
    assign lane.valid_out   = valid_q;
    assign lane.byte_strobe = strobe_q;
    assign lane.active_out  = (state == ST_ALIGNED);

endmodule

// File: tb/tb_alineador_rx.sv
// tb/tb_alineador_rx.sv - directed bench for alineador_rx
module tb_alineador_rx;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    always #5 clk_32f = ~clk_32f;

    alineador_rx_if lane ();

    alineador_rx #(
        .COM_SYMBOL    (8'hBC),
        .COM_COUNT     (4)
`ifdef ALINEADOR_TIMEOUT_EN
        ,
        .TIMEOUT_BYTES (4)
`endif
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .lane    (lane)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] strobe_pat;
    logic [7:0] data_mid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        lane.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[7-i]);
            strobe_pat[i] = lane.byte_strobe;
            if (i == 6) data_mid = lane.data_out;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        lane.data_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk_32f);
        #1;
        chk("rst_data",   lane.data_out,    8'h00);
        chk("rst_valid",  lane.valid_out,   1'b0);
        chk("rst_strobe", lane.byte_strobe, 1'b0);
        chk("rst_active", lane.active_out,  1'b0);
        reset = 1'b0;

        // clean lock after three garbage bits
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_byte(8'hBC);
        chk("lock_3rd_com", lane.active_out, 1'b0);
        send_byte(8'hBC);
        chk("lock_4th_com", lane.active_out, 1'b1);
        chk("lock_no_strobe", lane.byte_strobe, 1'b0);
        send_byte(8'h5A);
        chk("clean_data",  lane.data_out,  8'h5A);
        chk("clean_valid", lane.valid_out, 1'b1);
        chk("clean_strobe_pat", strobe_pat, 8'h80);

        // idle symbol while aligned
        send_byte(8'hBC);
        chk("idle_hold_mid", data_mid, 8'h5A);
        chk("idle_data",  lane.data_out,  8'hBC);
        chk("idle_valid", lane.valid_out, 1'b0);
        chk("idle_strobe_pat", strobe_pat, 8'h80);
        send_byte(8'hFF);
        chk("ff_data",  lane.data_out,  8'hFF);
        chk("ff_valid", lane.valid_out, 1'b1);

        // reset mid-byte, then relock on an aligned stream
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        pulse_reset();
        chk("midrst_data",   lane.data_out,    8'h00);
        chk("midrst_valid",  lane.valid_out,   1'b0);
        chk("midrst_strobe", lane.byte_strobe, 1'b0);
        chk("midrst_active", lane.active_out,  1'b0);
        repeat (3) send_byte(8'hBC);
        for (int i = 0; i < 7; i++) send_bit(i != 0 && i != 1 && i < 6 ? 1'b1 : (i == 0));
        chk("relock_31_cycles", lane.active_out, 1'b0);
        send_bit(1'b0);
        chk("relock_32_cycles", lane.active_out, 1'b1);

        // broken run of COMs
        pulse_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00);
        chk("broken_after_00", lane.active_out, 1'b0);
        repeat (3) send_byte(8'hBC);
        chk("broken_3_of_4", lane.active_out, 1'b0);
        send_byte(8'hBC);
        chk("broken_relock", lane.active_out, 1'b1);
        send_byte(8'h12);
        chk("broken_data",  lane.data_out,  8'h12);
        chk("broken_valid", lane.valid_out, 1'b1);

        // bit-offset stream
        pulse_reset();
        repeat (5) send_bit(1'($urandom_range(1, 0)));
        repeat (4) send_byte(8'hBC);
        chk("offset_lock", lane.active_out, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h3C);
            chk("offset_data_3c",  lane.data_out,  8'h3C);
            chk("offset_valid_3c", lane.valid_out, 1'b1);
            send_byte(8'hBC);
            chk("offset_data_bc",  lane.data_out,  8'hBC);
            chk("offset_valid_bc", lane.valid_out, 1'b0);
        end

`ifdef ALINEADOR_TIMEOUT_EN
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("to_still_active", lane.active_out, 1'b1);
        send_byte(8'h44);
        chk("to_data",       lane.data_out,   8'h44);
        chk("to_valid",      lane.valid_out,  1'b1);
        chk("to_strobe_pat", strobe_pat,      8'h80);
        chk("to_active_low", lane.active_out, 1'b0);
        send_byte(8'h55);
        chk("to_after_valid",  lane.valid_out, 1'b0);
        chk("to_after_strobe", strobe_pat,     8'h00);
        chk("to_after_data",   lane.data_out,  8'h44);
`else
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        chk("hold_lock", lane.active_out, 1'b1);
        chk("hold_data", lane.data_out,   8'h55);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
